sti_rx: RTL

STI_RX -- requirements
Module: sti_rx

---
 rtl/sti_pkg.sv | 41 ++++
 rtl/sti_rx_if.sv | 28 ++
 rtl/sti_rx_extract.sv | 46 ++++
 rtl/sti_rx.sv | 112 +++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared definitions for the STI serial link, used by the receiver and the transmitter.
package sti_pkg;

  typedef enum logic [1:0] {
    LEN_8  = 2'b00,
    LEN_16 = 2'b01,
    LEN_24 = 2'b10,
    LEN_32 = 2'b11
  } len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RECV = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int STAT_LEN = 0;
  localparam int STAT_PAD = 1;

  localparam logic [5:0] BIT_CNT_MAX = 6'd33;
  localparam logic [5:0] BIT_STORE   = 6'd32;

  typedef struct packed {
    len_e length;
    logic msb;
    logic low;
    logic fill;
  } cfg_t;

  function automatic logic [5:0] len_bits(input len_e code);
    logic [5:0] n;
    case (code)
      LEN_8:   n = 6'd8;
      LEN_16:  n = 6'd16;
      LEN_24:  n = 6'd24;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sti_rx_if.sv
// Configuration, serial input and parallel output signals of the STI receiver.
interface sti_rx_if;
  logic        cfg_load;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        cfg_low;
  logic        cfg_fill;
  logic        so_data;
  logic        so_valid;
  logic [15:0] po_data;
  logic [1:0]  po_status;
  logic        po_valid;
  logic        po_ready;
  logic        ovf;
  logic [7:0]  frm_cnt;

  modport master (
    output cfg_load, cfg_length, cfg_msb, cfg_low, cfg_fill,
    output so_data, so_valid, po_ready,
    input  po_data, po_status, po_valid, ovf, frm_cnt
  );

  modport slave (
    input  cfg_load, cfg_length, cfg_msb, cfg_low, cfg_fill,
    input  so_data, so_valid, po_ready,
    output po_data, po_status, po_valid, ovf, frm_cnt
  );
endinterface

// File: rtl/sti_rx_extract.sv
// Payload and status extraction from a captured frame word.
module sti_rx_extract
  import sti_pkg::*;
(
  input  logic [31:0] frame,
  input  logic [5:0]  bit_cnt,
  input  cfg_t        cfg,
  output logic [15:0] data,
  output logic [1:0]  status
);

  logic len_err;
  logic pad_err;
  logic [15:0] payload;

  always_comb begin
    payload = 16'h0000;
    pad_err = 1'b0;
    len_err = (bit_cnt != len_bits(cfg.length));
    case (cfg.length)
      LEN_8:  payload = cfg.low ? {frame[7:0], 8'h00} : {8'h00, frame[7:0]};
      LEN_16: payload = frame[15:0];
      LEN_24: begin
        payload = cfg.fill ? frame[23:8] : frame[15:0];
        pad_err = cfg.fill ? |frame[7:0] : |frame[23:16];
      end
      default: begin
        payload = cfg.fill ? frame[31:16] : frame[15:0];
        pad_err = cfg.fill ? |frame[15:0] : |frame[31:16];
      end
    endcase
    // A wrong-length frame carries no payload, and its padding is meaningless.
    if (len_err) begin
      payload = 16'h0000;
      pad_err = 1'b0;
    end
  end

  assign data = payload;
  always_comb begin
    status           = 2'b00;
    status[STAT_LEN] = len_err;
    status[STAT_PAD] = pad_err;
  end

endmodule

// File: rtl/sti_rx.sv
// STI serial receiver: captures a frame, extracts a 16-bit payload, holds it in an output slot.
//   state   | meaning
//   ST_IDLE | no frame; configuration may be loaded
//   ST_RECV | frame active, bits being sampled
//   ST_DONE | frame ended; offer result to the output slot
module sti_rx
  import sti_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  sti_rx_if.slave  bus
);

  state_e      state_q, state_d;
  cfg_t        cfg_q;
  logic [31:0] frame_q;
  logic [5:0]  bit_cnt_q;
  logic [15:0] ext_data;
  logic [1:0]  ext_status;
  logic        frame_start;
  logic        slot_load;
  logic        slot_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    slot_load   = 1'b0;
    slot_drop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.so_valid) begin
          state_d     = ST_RECV;
          frame_start = 1'b1;
        end
      end
      ST_RECV: begin
        if (!bus.so_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        slot_load   = !bus.po_valid || bus.po_ready;
        slot_drop   = bus.po_valid && !bus.po_ready;
        frame_start = bus.so_valid;
        state_d     = bus.so_valid ? ST_RECV : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q <= '{length: LEN_8, msb: 1'b0, low: 1'b0, fill: 1'b0};
    end else if (bus.cfg_load && state_q == ST_IDLE) begin
      cfg_q <= '{length: len_e'(bus.cfg_length), msb: bus.cfg_msb,
                 low: bus.cfg_low, fill: bus.cfg_fill};
    end
  end

  // A new frame restarts capture on the same edge the previous one is handed off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q   <= 32'h0;
      bit_cnt_q <= 6'd0;
    end else if (bus.so_valid) begin
      if (frame_start) begin
        frame_q   <= {31'h0, bus.so_data};
        bit_cnt_q <= 6'd1;
      end else begin
        if (bit_cnt_q < BIT_CNT_MAX) bit_cnt_q <= bit_cnt_q + 6'd1;
        if (bit_cnt_q < BIT_STORE) begin
          if (cfg_q.msb) frame_q <= {frame_q[30:0], bus.so_data};
          else           frame_q[bit_cnt_q[4:0]] <= bus.so_data;
        end
      end
    end
  end

  sti_rx_extract u_extract (
    .frame   (frame_q),
    .bit_cnt (bit_cnt_q),
    .cfg     (cfg_q),
    .data    (ext_data),
    .status  (ext_status)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.po_data   <= 16'h0;
      bus.po_status <= 2'b00;
      bus.po_valid  <= 1'b0;
      bus.frm_cnt   <= 8'h0;
    end else if (slot_load) begin
      bus.po_data   <= ext_data;
      bus.po_status <= ext_status;
      bus.po_valid  <= 1'b1;
      bus.frm_cnt   <= bus.frm_cnt + 8'd1;
    end else if (bus.po_ready) begin
      bus.po_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    bus.ovf <= 1'b0;
    else if (slot_drop)                            bus.ovf <= 1'b1;
    else if (bus.cfg_load && state_q == ST_IDLE)   bus.ovf <= 1'b0;
  end

endmodule
